// File: rtl/svc_uart_rx_if.sv
// Receive-side byte stream of svc_uart_rx: valid/ready handshake plus
// single-cycle error pulses.
interface svc_uart_rx_if;
    logic       urx_valid;
    logic [7:0] urx_data;
    logic       urx_ready;
    logic       urx_frame_err;
    logic       urx_overrun;

    modport master (
        output urx_valid,
        output urx_data,
        output urx_frame_err,
        output urx_overrun,
        input  urx_ready
    );

    modport slave (
        input  urx_valid,
        input  urx_data,
        input  urx_frame_err,
        input  urx_overrun,
        output urx_ready
    );
endinterface

// File: rtl/svc_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a fixed divider, one-deep
// output register, frame-error and overrun pulses.
module svc_uart_rx #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              urx_pin,
    svc_uart_rx_if.master     urx
);

    localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CW         = $clog2(BIT_CYCLES);

    localparam logic [CW-1:0] LOAD_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] LOAD_BIT  = CW'(BIT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [1:0]    sync_q;
    logic          rx_s;
    logic [2:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          valid_q;
    logic [7:0]    data_q;
    logic          ferr_q;
    logic          ovr_q;
    logic          tc;
    logic          accept;

    assign rx_s   = sync_q[1];
    assign tc     = (cnt_q == '0);
    assign accept = !valid_q || urx.urx_ready;

    assign urx.urx_valid     = valid_q;
    assign urx.urx_data      = data_q;
    assign urx.urx_frame_err = ferr_q;
    assign urx.urx_overrun   = ovr_q;

    // Pin is asynchronous; idle-high reset avoids a false start at release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], urx_pin};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (valid_q && urx.urx_ready) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt_q   <= LOAD_HALF;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (!tc) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rx_s) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= LOAD_BIT;
                        idx_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!tc) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= LOAD_BIT;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (!tc) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rx_s) begin
                        state_q <= S_IDLE;
                        // Overrides the handshake clear: no bubble.
                        if (accept) begin
                            valid_q <= 1'b1;
                            data_q  <= shift_q;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end else begin
                        ferr_q  <= 1'b1;
                        state_q <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_svc_uart_rx.sv
// Directed bench for svc_uart_rx at BIT_CYCLES=10 with a byte
// scoreboard and cycle-exact latency checks.
module tb_svc_uart_rx;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic urx_pin = 1'b1;

    svc_uart_rx_if u ();

    svc_uart_rx #(
        .CLOCK_FREQ(100),
        .BAUD_RATE (10)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .urx_pin(urx_pin),
        .urx    (u)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    int n_hs = 0, n_vcyc = 0, n_ferr = 0, n_ovr = 0;
    int hs_cyc = 0, prev_hs_cyc = 0, ovr_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (u.urx_valid) n_vcyc++;
            if (u.urx_frame_err) n_ferr++;
            if (u.urx_overrun) begin
                n_ovr++;
                ovr_cyc = cyc;
            end
            if (u.urx_valid && u.urx_ready) begin
                n_hs++;
                prev_hs_cyc = hs_cyc;
                hs_cyc = cyc;
                got_q.push_back(u.urx_data);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop,
                        output int fall);
        fall = cyc;
        urx_pin = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            urx_pin = b[i];
            repeat (10) @(negedge clk);
        end
        urx_pin = stop;
        repeat (10) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++)
            @(negedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() != 0 && exp_q.size() != 0)
            chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    int f0, f1, hs0, v0, fe0, ov0;

    initial begin
        u.urx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", u.urx_valid, 0);
        chk("rst_data", u.urx_data, 0);
        chk("rst_ferr", u.urx_frame_err, 0);
        chk("rst_ovr", u.urx_overrun, 0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("idle_valid", u.urx_valid, 0);
        chk("idle_data", u.urx_data, 0);
        chk("idle_ferr_cnt", n_ferr, 0);
        chk("idle_ovr_cnt", n_ovr, 0);
        chk("idle_vcyc", n_vcyc, 0);

        // Single frame, latency from pin fall to valid.
        hs0 = n_hs; v0 = n_vcyc; fe0 = n_ferr; ov0 = n_ovr;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, f0);
        drain("a5");
        chk("a5_hs", n_hs - hs0, 1);
        chk("a5_latency", hs_cyc - f0, 98);
        chk("a5_vcyc", n_vcyc - v0, 1);
        chk("a5_ferr", n_ferr - fe0, 0);
        chk("a5_ovr", n_ovr - ov0, 0);

        // Back-to-back frames, no idle gap.
        hs0 = n_hs;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send(8'h55, 1'b1, f0);
        send(8'hAA, 1'b1, f1);
        drain("b2b");
        chk("b2b_hs", n_hs - hs0, 2);
        chk("b2b_gap", hs_cyc - prev_hs_cyc, 100);

        // Short glitch is rejected at the start check.
        hs0 = n_hs; fe0 = n_ferr;
        urx_pin = 1'b0;
        repeat (3) @(negedge clk);
        urx_pin = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_hs", n_hs - hs0, 0);
        chk("glitch_ferr", n_ferr - fe0, 0);
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1, f0);
        drain("3c");

        // Framing error followed by a held-low line.
        v0 = n_vcyc; fe0 = n_ferr;
        send(8'h81, 1'b0, f0);
        repeat (290) @(negedge clk);
        chk("brk_ferr", n_ferr - fe0, 1);
        chk("brk_vcyc", n_vcyc - v0, 0);
        urx_pin = 1'b1;
        repeat (20) @(negedge clk);
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b1, f0);
        drain("7e");
        chk("brk_ferr_after", n_ferr - fe0, 1);

        // Overrun with consumer stalled.
        u.urx_ready = 1'b0;
        ov0 = n_ovr; hs0 = n_hs;
        send(8'h11, 1'b1, f0);
        send(8'h22, 1'b1, f1);
        repeat (5) @(negedge clk);
        chk("ovr_valid", u.urx_valid, 1);
        chk("ovr_data", u.urx_data, 8'h11);
        chk("ovr_cnt", n_ovr - ov0, 1);
        chk("ovr_when", ovr_cyc - f1, 98);
        exp_q.push_back(8'h11);
        u.urx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovr_valid_clr", u.urx_valid, 0);
        chk("ovr_hs", n_hs - hs0, 1);
        drain("ovr");

        // Asynchronous reset mid-DATA.
        u.urx_ready = 1'b0;
        send(8'h33, 1'b1, f0);
        repeat (5) @(negedge clk);
        chk("pre_rst_valid", u.urx_valid, 1);
        chk("pre_rst_data", u.urx_data, 8'h33);
        urx_pin = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", u.urx_valid, 0);
        chk("arst_data", u.urx_data, 0);
        chk("arst_ferr", u.urx_frame_err, 0);
        chk("arst_ovr", u.urx_overrun, 0);
        urx_pin = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        u.urx_ready = 1'b1;
        hs0 = n_hs; fe0 = n_ferr;
        repeat (30) @(negedge clk);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, f0);
        drain("5a");
        chk("5a_hs", n_hs - hs0, 1);
        chk("5a_ferr", n_ferr - fe0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
